// File: rtl/hazard_stall_unit_if.sv
// ID-stage hazard bundle: source operands and pipeline producers in, stall controls out.
// The master side belongs to the pipeline; the slave side belongs to hazard_stall_unit.
interface hazard_stall_unit_if #(
   parameter int AW    = 5,
   parameter int CNT_W = 16
);
   logic          id_valid;
   logic [AW-1:0] id_rs1;
   logic [AW-1:0] id_rs2;
   logic          id_use_rs1;
   logic          id_use_rs2;
   logic          id_is_branch;
   logic [AW-1:0] ex_rd;
   logic [AW-1:0] mem_rd;
   logic [AW-1:0] wb_rd;
   logic          ex_regwrite;
   logic          mem_regwrite;
   logic          wb_regwrite;
   logic          ex_is_load;
   logic          mem_is_load;
   logic          flush;
   logic          bubble;
   logic          pc_en;
   logic          if_id_en;
   logic [1:0]    cause;
   logic [1:0]    stall_cnt;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch,
      output ex_rd, mem_rd, wb_rd, ex_regwrite, mem_regwrite, wb_regwrite,
      output ex_is_load, mem_is_load, flush,
      input  bubble, pc_en, if_id_en, cause, stall_cnt, stall_cycles
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch,
      input  ex_rd, mem_rd, wb_rd, ex_regwrite, mem_regwrite, wb_regwrite,
      input  ex_is_load, mem_is_load, flush,
      output bubble, pc_en, if_id_en, cause, stall_cnt, stall_cycles
   );
endinterface

// File: rtl/hazard_stall_unit.sv
// ID-stage stall controller: detects load-use and ID-branch RAW hazards and
// inserts the required number of bubbles through a down-counting stall FSM.
module hazard_stall_unit #(
   parameter int AW           = 5,
   parameter int LOAD_BUBBLES = 1,
   parameter int RF_BYPASS    = 0,
   parameter int X0_HARDWIRED = 1,
   parameter int CNT_W        = 16
) (
   input  logic clk,
   input  logic rst,
   hazard_stall_unit_if.slave bus
);
   typedef enum logic {S_IDLE, S_STALL} state_t;

   // Branch operands are compared in ID, so an older producer needs fewer bubbles.
   localparam logic [1:0] BR_EX  = 2'(3 - RF_BYPASS);
   localparam logic [1:0] BR_MEM = 2'(2 - RF_BYPASS);
   localparam logic [1:0] BR_WB  = 2'(1 - RF_BYPASS);
   localparam logic [1:0] LD_EX  = 2'(LOAD_BUBBLES);

   state_t           r_state;
   logic [1:0]       r_stall_cnt;
   logic [1:0]       r_cause;
   logic [CNT_W-1:0] r_stall_cycles;

   logic [AW-1:0] w_rd [3];
   logic [2:0]    w_we;
   logic [2:0]    w_match;
   logic [1:0]    w_br_need;
   logic [1:0]    w_ld_need;
   logic [1:0]    w_need;
   logic [1:0]    w_cause;
   logic          w_bubble;

   assign w_rd[0] = bus.ex_rd;
   assign w_rd[1] = bus.mem_rd;
   assign w_rd[2] = bus.wb_rd;
   assign w_we    = {bus.wb_regwrite, bus.mem_regwrite, bus.ex_regwrite};

   always_comb begin
      w_match = '0;
      for (int i = 0; i < 3; i++) begin
         w_match[i] = bus.id_valid & w_we[i]
                    & (((w_rd[i] == bus.id_rs1) & bus.id_use_rs1)
                     | ((w_rd[i] == bus.id_rs2) & bus.id_use_rs2))
                    & ((X0_HARDWIRED == 0) | (w_rd[i] != '0));
      end
   end

   always_comb begin
      w_br_need = 2'd0;
      if (bus.id_is_branch) begin
         if (w_match[0])      w_br_need = BR_EX;
         else if (w_match[1]) w_br_need = BR_MEM;
         else if (w_match[2]) w_br_need = BR_WB;
      end
      w_ld_need = 2'd0;
      if (w_match[0] & bus.ex_is_load)
         w_ld_need = LD_EX;
      else if (w_match[1] & bus.mem_is_load & (LOAD_BUBBLES == 2))
         w_ld_need = 2'd1;
   end

   assign w_need   = (w_br_need > w_ld_need) ? w_br_need : w_ld_need;
   assign w_cause  = {w_br_need != 2'd0, w_ld_need != 2'd0};
   assign w_bubble = ~rst & ~bus.flush & ((r_state == S_STALL) | (w_need != 2'd0));

   assign bus.bubble       = w_bubble;
   assign bus.pc_en        = ~w_bubble;
   assign bus.if_id_en     = ~w_bubble;
   assign bus.cause        = r_cause;
   assign bus.stall_cnt    = r_stall_cnt;
   assign bus.stall_cycles = r_stall_cycles;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_stall_cnt    <= 2'd0;
         r_cause        <= 2'b00;
         r_stall_cycles <= '0;
      end else begin
         if (w_bubble && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         if (bus.flush) begin
            r_state     <= S_IDLE;
            r_stall_cnt <= 2'd0;
            r_cause     <= 2'b00;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_need != 2'd0) begin
                     r_stall_cnt <= w_need - 2'd1;
                     r_cause     <= w_cause;
                     r_state     <= (w_need > 2'd1) ? S_STALL : S_IDLE;
                  end else begin
                     r_cause <= 2'b00;
                  end
               end
               S_STALL: begin
                  // The held ID instruction is not re-examined until the count drains.
                  r_stall_cnt <= r_stall_cnt - 2'd1;
                  if (r_stall_cnt == 2'd1) r_state <= S_IDLE;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Drives four differently-parameterised hazard_stall_unit instances with one shared
// stimulus stream and scoreboards each against a per-cycle behavioural model.
module tb_hazard_stall_unit;
   typedef struct packed {
      logic       vld;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1, u2, br;
      logic [4:0] exrd, memrd, wbrd;
      logic       exw, memw, wbw, exl, meml, fl;
   } in_t;

   typedef struct packed {
      logic [3:0]       bub;
      logic [3:0][1:0]  cnt;
      logic [3:0][1:0]  cause;
      logic [3:0][15:0] cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   in_t  s_in;
   exp_t q[$];
   int   total = 0;
   int   bad = 0;

   // config 0 default, 1 RF_BYPASS, 2 X0 not hardwired, 3 LOAD_BUBBLES=2 with CNT_W=4
   int lb[4]   = '{1, 1, 1, 2};
   int byp[4]  = '{0, 1, 0, 0};
   int x0[4]   = '{1, 1, 0, 1};
   int cmax[4] = '{65535, 65535, 65535, 15};
   int m_cnt[4], m_cause[4], m_cyc[4];

   hazard_stall_unit_if #(.AW(5), .CNT_W(16)) if0 ();
   hazard_stall_unit_if #(.AW(5), .CNT_W(16)) if1 ();
   hazard_stall_unit_if #(.AW(5), .CNT_W(16)) if2 ();
   hazard_stall_unit_if #(.AW(5), .CNT_W(4))  if3 ();

   hazard_stall_unit u0 (.clk(clk), .rst(rst), .bus(if0.slave));
   hazard_stall_unit #(.RF_BYPASS(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
   hazard_stall_unit #(.X0_HARDWIRED(0)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
   hazard_stall_unit #(.LOAD_BUBBLES(2), .CNT_W(4)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

   always #5 clk = ~clk;

   always_comb begin
      if0.id_valid = s_in.vld; if0.id_rs1 = s_in.rs1; if0.id_rs2 = s_in.rs2;
      if0.id_use_rs1 = s_in.u1; if0.id_use_rs2 = s_in.u2; if0.id_is_branch = s_in.br;
      if0.ex_rd = s_in.exrd; if0.mem_rd = s_in.memrd; if0.wb_rd = s_in.wbrd;
      if0.ex_regwrite = s_in.exw; if0.mem_regwrite = s_in.memw; if0.wb_regwrite = s_in.wbw;
      if0.ex_is_load = s_in.exl; if0.mem_is_load = s_in.meml; if0.flush = s_in.fl;
   end
   always_comb begin
      if1.id_valid = s_in.vld; if1.id_rs1 = s_in.rs1; if1.id_rs2 = s_in.rs2;
      if1.id_use_rs1 = s_in.u1; if1.id_use_rs2 = s_in.u2; if1.id_is_branch = s_in.br;
      if1.ex_rd = s_in.exrd; if1.mem_rd = s_in.memrd; if1.wb_rd = s_in.wbrd;
      if1.ex_regwrite = s_in.exw; if1.mem_regwrite = s_in.memw; if1.wb_regwrite = s_in.wbw;
      if1.ex_is_load = s_in.exl; if1.mem_is_load = s_in.meml; if1.flush = s_in.fl;
   end
   always_comb begin
      if2.id_valid = s_in.vld; if2.id_rs1 = s_in.rs1; if2.id_rs2 = s_in.rs2;
      if2.id_use_rs1 = s_in.u1; if2.id_use_rs2 = s_in.u2; if2.id_is_branch = s_in.br;
      if2.ex_rd = s_in.exrd; if2.mem_rd = s_in.memrd; if2.wb_rd = s_in.wbrd;
      if2.ex_regwrite = s_in.exw; if2.mem_regwrite = s_in.memw; if2.wb_regwrite = s_in.wbw;
      if2.ex_is_load = s_in.exl; if2.mem_is_load = s_in.meml; if2.flush = s_in.fl;
   end
   always_comb begin
      if3.id_valid = s_in.vld; if3.id_rs1 = s_in.rs1; if3.id_rs2 = s_in.rs2;
      if3.id_use_rs1 = s_in.u1; if3.id_use_rs2 = s_in.u2; if3.id_is_branch = s_in.br;
      if3.ex_rd = s_in.exrd; if3.mem_rd = s_in.memrd; if3.wb_rd = s_in.wbrd;
      if3.ex_regwrite = s_in.exw; if3.mem_regwrite = s_in.memw; if3.wb_regwrite = s_in.wbw;
      if3.ex_is_load = s_in.exl; if3.mem_is_load = s_in.meml; if3.flush = s_in.fl;
   end

   logic [3:0]       a_bub, a_pc, a_ifid;
   logic [3:0][1:0]  a_cnt, a_cause;
   logic [3:0][15:0] a_cyc;
   always_comb begin
      a_bub   = {if3.bubble, if2.bubble, if1.bubble, if0.bubble};
      a_pc    = {if3.pc_en, if2.pc_en, if1.pc_en, if0.pc_en};
      a_ifid  = {if3.if_id_en, if2.if_id_en, if1.if_id_en, if0.if_id_en};
      a_cnt   = {if3.stall_cnt, if2.stall_cnt, if1.stall_cnt, if0.stall_cnt};
      a_cause = {if3.cause, if2.cause, if1.cause, if0.cause};
      a_cyc   = {16'(if3.stall_cycles), if2.stall_cycles, if1.stall_cycles, if0.stall_cycles};
   end

   function automatic int imax(int a, int b);
      return (a > b) ? a : b;
   endfunction

   // Bubbles required by the instruction in ID, from the hazard rules directly.
   function automatic void calc(input int c, input in_t x, output int need, output int cs);
      int  rd[3];
      bit  we[3];
      bit  m[3];
      int  br, ld;
      rd = '{int'(x.exrd), int'(x.memrd), int'(x.wbrd)};
      we = '{x.exw, x.memw, x.wbw};
      for (int s = 0; s < 3; s++)
         m[s] = x.vld && we[s] && ((rd[s] == int'(x.rs1) && x.u1) || (rd[s] == int'(x.rs2) && x.u2))
                && (x0[c] == 0 || rd[s] != 0);
      br = 0;
      if (x.br)
         for (int s = 0; s < 3; s++) if (m[s]) br = imax(br, 3 - s - byp[c]);
      ld = 0;
      if (m[0] && x.exl) ld = lb[c];
      if (m[1] && x.meml && lb[c] == 2) ld = imax(ld, 1);
      need = imax(br, ld);
      cs = (br > 0 ? 2 : 0) + (ld > 0 ? 1 : 0);
   endfunction

   task automatic step(input in_t x, input logic r);
      exp_t e;
      int   need, cs, b;
      s_in = x;
      rst  = r;
      for (int c = 0; c < 4; c++) begin
         calc(c, x, need, cs);
         e.cnt[c] = 2'(m_cnt[c]); e.cause[c] = 2'(m_cause[c]); e.cyc[c] = 16'(m_cyc[c]);
         if (r) begin
            b = 0; m_cnt[c] = 0; m_cause[c] = 0; m_cyc[c] = 0;
         end else if (x.fl) begin
            b = 0; m_cnt[c] = 0; m_cause[c] = 0;
         end else if (m_cnt[c] != 0) begin
            b = 1; m_cnt[c]--;
         end else if (need != 0) begin
            b = 1; m_cnt[c] = need - 1; m_cause[c] = cs;
         end else begin
            b = 0; m_cause[c] = 0;
         end
         if (!r && b == 1 && m_cyc[c] < cmax[c]) m_cyc[c]++;
         e.bub[c] = (b == 1);
      end
      q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic chk(input string nm, input int c, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s cfg%0d got=%0d exp=%0d at %0t", nm, c, act, expv, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            for (int c = 0; c < 4; c++) begin
               chk("bubble", c, int'(a_bub[c]), int'(e.bub[c]));
               chk("pc_en", c, int'(a_pc[c]), int'(!e.bub[c]));
               chk("if_id_en", c, int'(a_ifid[c]), int'(!e.bub[c]));
               chk("stall_cnt", c, int'(a_cnt[c]), int'(e.cnt[c]));
               chk("cause", c, int'(a_cause[c]), int'(e.cause[c]));
               chk("stall_cycles", c, int'(a_cyc[c]), int'(e.cyc[c]));
            end
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, 1'b0);
   endtask

   initial begin : stim
      in_t x;
      for (int c = 0; c < 4; c++) begin m_cnt[c] = 0; m_cause[c] = 0; m_cyc[c] = 0; end
      s_in = '0;
      rst  = 1'b1;
      @(posedge clk); #1;
      step('0, 1'b1);
      idle(2);
      // load-use on rs2
      x = '0; x.vld = 1; x.exl = 1; x.exw = 1; x.exrd = 5; x.rs2 = 5; x.u2 = 1;
      step(x, 0); idle(2);
      // branch against ex producer, ID held for the stall
      x = '0; x.vld = 1; x.br = 1; x.rs1 = 7; x.u1 = 1; x.exrd = 7; x.exw = 1;
      for (int i = 0; i < 3; i++) step(x, 0);
      idle(2);
      // branch with producer only in wb
      x = '0; x.vld = 1; x.br = 1; x.rs1 = 7; x.u1 = 1; x.wbrd = 7; x.wbw = 1;
      step(x, 0); idle(1);
      // x0 producer, then unused rs2 match
      x = '0; x.vld = 1; x.rs1 = 0; x.u1 = 1; x.exrd = 0; x.exw = 1; x.exl = 1;
      step(x, 0); idle(1);
      x = '0; x.vld = 1; x.rs2 = 9; x.u2 = 0; x.exrd = 9; x.exw = 1; x.exl = 1;
      step(x, 0); idle(1);
      // flush in the second cycle of a branch stall
      x = '0; x.vld = 1; x.br = 1; x.rs1 = 7; x.u1 = 1; x.exrd = 7; x.exw = 1;
      step(x, 0); x.fl = 1; step(x, 0); idle(2);
      // load in mem only, then branch plus load in ex
      x = '0; x.vld = 1; x.rs1 = 3; x.u1 = 1; x.memrd = 3; x.memw = 1; x.meml = 1;
      step(x, 0); idle(2);
      x = '0; x.vld = 1; x.br = 1; x.rs1 = 4; x.u1 = 1; x.exrd = 4; x.exw = 1; x.exl = 1;
      for (int i = 0; i < 3; i++) step(x, 0);
      idle(2);
      // long hazard to saturate the narrow counter, then reset mid-stall
      x = '0; x.vld = 1; x.br = 1; x.rs1 = 6; x.u1 = 1; x.exrd = 6; x.exw = 1;
      for (int i = 0; i < 25; i++) step(x, 0);
      step(x, 0); step(x, 1); step(x, 0);
      idle(3);
      // randomized traffic over a small register window to force frequent matches
      for (int i = 0; i < 2000; i++) begin
         x.vld   = ($urandom_range(0, 7) != 0);
         x.rs1   = 5'($urandom_range(0, 3)); x.rs2 = 5'($urandom_range(0, 3));
         x.u1    = 1'($urandom); x.u2 = 1'($urandom); x.br = 1'($urandom);
         x.exrd  = 5'($urandom_range(0, 3)); x.memrd = 5'($urandom_range(0, 3));
         x.wbrd  = 5'($urandom_range(0, 3));
         x.exw   = 1'($urandom); x.memw = 1'($urandom); x.wbw = 1'($urandom);
         x.exl   = 1'($urandom); x.meml = 1'($urandom);
         x.fl    = ($urandom_range(0, 15) == 0);
         step(x, ($urandom_range(0, 63) == 0));
      end
      idle(2);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d exp=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
